// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider with start/busy/done handshake and compare flags
// Optional feature macro: SEQ_DIV_SIGNED_EN (adds op_signed port, FIX state, signed compares)
module seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SEQ_DIV_SIGNED_EN
   input  logic             op_signed,
`endif
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             greater,
   output logic             equal,
   output logic             less
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef SEQ_DIV_SIGNED_EN
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

   state_t           state;
   logic [CNT_W-1:0] cnt;
   // rem_r is the running partial remainder; quo_r starts as the dividend
   // and fills with quotient bits from the bottom as dividend bits leave the top.
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] dvs_r;
   logic             gt_r;
   logic             eq_r;
   logic             lt_r;
`ifdef SEQ_DIV_SIGNED_EN
   logic             sgn_r;
   logic             neg_q;
   logic             neg_r;
`endif

   logic             sgn_req;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             cmp_gt;
   logic             cmp_eq;
   logic             cmp_lt;

   // Accept-time decode: operand magnitudes and compare flags from the raw inputs
   always_comb begin
`ifdef SEQ_DIV_SIGNED_EN
      sgn_req = op_signed;
`else
      sgn_req = 1'b0;
`endif
      a_neg  = sgn_req & rs1[WIDTH-1];
      b_neg  = sgn_req & rs2[WIDTH-1];
      a_mag  = a_neg ? (-rs1) : rs1;
      b_mag  = b_neg ? (-rs2) : rs2;
      cmp_eq = (rs1 == rs2);
      if (sgn_req) begin
         cmp_lt = ($signed(rs1) < $signed(rs2));
      end else begin
         cmp_lt = (rs1 < rs2);
      end
      cmp_gt = ~cmp_eq & ~cmp_lt;
   end

   logic [WIDTH:0]   partial;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   // One restoring step: a set top bit of the trial difference means it went negative
   always_comb begin
      partial = {rem_r, quo_r[WIDTH-1]};
      trial   = partial - {1'b0, dvs_r};
      rem_nxt = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_nxt = {quo_r[WIDTH-2:0], ~trial[WIDTH]};
   end

   // Control FSM, iteration datapath and registered result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         rem_r       <= '0;
         quo_r       <= '0;
         dvs_r       <= '0;
         gt_r        <= 1'b0;
         eq_r        <= 1'b0;
         lt_r        <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
         sgn_r       <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         greater     <= 1'b0;
         equal       <= 1'b0;
         less        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  cnt   <= '0;
                  rem_r <= '0;
                  quo_r <= a_mag;
                  dvs_r <= b_mag;
                  gt_r  <= cmp_gt;
                  eq_r  <= cmp_eq;
                  lt_r  <= cmp_lt;
`ifdef SEQ_DIV_SIGNED_EN
                  sgn_r <= sgn_req;
                  neg_q <= a_neg ^ b_neg;
                  neg_r <= a_neg;
`endif
                  if (rs2 == '0) begin
                     // Divide by zero finishes immediately without iterating.
                     state       <= DONE;
                     done        <= 1'b1;
                     quotient    <= '1;
                     remainder   <= rs1;
                     div_by_zero <= 1'b1;
                     greater     <= cmp_gt;
                     equal       <= cmp_eq;
                     less        <= cmp_lt;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               rem_r <= rem_nxt;
               quo_r <= quo_nxt;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST_CNT) begin
`ifdef SEQ_DIV_SIGNED_EN
                  if (sgn_r) begin
                     state <= FIX;
                  end else begin
`endif
                     state       <= DONE;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     quotient    <= quo_nxt;
                     remainder   <= rem_nxt;
                     div_by_zero <= 1'b0;
                     greater     <= gt_r;
                     equal       <= eq_r;
                     less        <= lt_r;
`ifdef SEQ_DIV_SIGNED_EN
                  end
`endif
               end
            end
`ifdef SEQ_DIV_SIGNED_EN
            FIX: begin
               // Restore signs; most-negative / -1 wraps back to most-negative.
               state       <= DONE;
               busy        <= 1'b0;
               done        <= 1'b1;
               quotient    <= neg_q ? (-quo_r) : quo_r;
               remainder   <= neg_r ? (-rem_r) : rem_r;
               div_by_zero <= 1'b0;
               greater     <= gt_r;
               equal       <= eq_r;
               less        <= lt_r;
            end
`endif
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
